// File: rtl/matmul_seq.sv
// Sequencer for a small N x K x M matrix multiply: clears the PEs, feeds K operands, drains the array, then writes N*M results.
// Optional misuse detection (sticky err_o on control writes while busy) is enabled by defining MATMUL_SEQ_ERR_CHECK_EN.
module matmul_seq (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] control_register_i,
    input  logic        ctrl_wr_i,
    output logic        busy_o,
    output logic        pe_clr_o,
    output logic        feed_en_o,
    output logic [1:0]  feed_idx_o,
    output logic        wr_en_o,
    output logic [1:0]  wr_row_o,
    output logic [1:0]  wr_col_o,
    output logic [1:0]  wr_target_o,
    output logic [1:0]  dataflow_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic        start_q;
    logic [1:0]  n_q, k_q, m_q;
    logic [1:0]  wr_target_q, dataflow_q;
    logic [4:0]  cnt_q;
    logic [1:0]  row_q, col_q;
    logic        launch;
    logic [2:0]  n_dim, m_dim;
    logic [4:0]  prod;
    logic [4:0]  drain_last;
    logic [4:0]  prod_last;

    // Dimension fields hold size-1, so the last-cycle indices fall out of the raw fields.
    assign n_dim      = {1'b0, n_q} + 3'd1;
    assign m_dim      = {1'b0, m_q} + 3'd1;
    assign prod       = {2'b00, n_dim} * {2'b00, m_dim};
    assign prod_last  = prod - 5'd1;
    assign drain_last = {3'b000, n_q} + {3'b000, m_q};

    assign launch = (state_q == IDLE) && control_register_i[0] && !start_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (launch) state_d = CLEAR;
            CLEAR:   state_d = FEED;
            FEED:    if (cnt_q == {3'b000, k_q}) state_d = DRAIN;
            DRAIN:   if (cnt_q == drain_last) state_d = WRITE;
            WRITE:   if (cnt_q == prod_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            start_q     <= control_register_i[0];
            n_q         <= 2'd0;
            k_q         <= 2'd0;
            m_q         <= 2'd0;
            wr_target_q <= 2'd0;
            dataflow_q  <= 2'd0;
            cnt_q       <= 5'd0;
            row_q       <= 2'd0;
            col_q       <= 2'd0;
        end else begin
            state_q <= state_d;
            start_q <= control_register_i[0];
            if (launch) begin
                n_q         <= control_register_i[9:8];
                k_q         <= control_register_i[11:10];
                m_q         <= control_register_i[13:12];
                wr_target_q <= control_register_i[3:2];
                dataflow_q  <= control_register_i[7:6];
            end
            // One phase counter, restarted on every state change.
            if (state_q != state_d || state_q == IDLE)
                cnt_q <= 5'd0;
            else
                cnt_q <= cnt_q + 5'd1;
            if (state_d != WRITE) begin
                row_q <= 2'd0;
                col_q <= 2'd0;
            end else if (state_q == WRITE) begin
                if (col_q == m_q) begin
                    col_q <= 2'd0;
                    row_q <= row_q + 2'd1;
                end else begin
                    col_q <= col_q + 2'd1;
                end
            end
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign pe_clr_o    = (state_q == CLEAR);
    assign feed_en_o   = (state_q == FEED);
    assign feed_idx_o  = (state_q == FEED) ? cnt_q[1:0] : 2'd0;
    assign wr_en_o     = (state_q == WRITE);
    assign wr_row_o    = (state_q == WRITE) ? row_q : 2'd0;
    assign wr_col_o    = (state_q == WRITE) ? col_q : 2'd0;
    assign wr_target_o = wr_target_q;
    assign dataflow_o  = dataflow_q;
    assign done_o      = (state_q == DONE);

`ifdef MATMUL_SEQ_ERR_CHECK_EN
    logic err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            err_q <= 1'b0;
        else if (launch)
            err_q <= 1'b0;
        else if (ctrl_wr_i && busy_o)
            err_q <= 1'b1;
    end

    assign err_o = err_q;

    logic unused_fields;
    assign unused_fields = &{1'b0, control_register_i[15:14], control_register_i[5:4], control_register_i[1]};
`else
    assign err_o = 1'b0;

    logic unused_fields;
    assign unused_fields = &{1'b0, ctrl_wr_i, control_register_i[15:14], control_register_i[5:4], control_register_i[1]};
`endif

endmodule

// File: tb/tb_matmul_seq.sv
// Self-checking bench for matmul_seq: randomized jobs compared cycle by cycle against a schedule model
// derived from the phase lengths (clear 1, feed K, drain N+M-1, write N*M, done 1).
module tb_matmul_seq;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] control_register_i;
    logic        ctrl_wr_i;
    logic        busy_o, pe_clr_o, feed_en_o, wr_en_o, done_o, err_o;
    logic [1:0]  feed_idx_o, wr_row_o, wr_col_o, wr_target_o, dataflow_o;

    int errors = 0;
    int checks = 0;
    bit err_model = 1'b0;

    always #5 clk_i = ~clk_i;

    matmul_seq dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .control_register_i (control_register_i),
        .ctrl_wr_i          (ctrl_wr_i),
        .busy_o             (busy_o),
        .pe_clr_o           (pe_clr_o),
        .feed_en_o          (feed_en_o),
        .feed_idx_o         (feed_idx_o),
        .wr_en_o            (wr_en_o),
        .wr_row_o           (wr_row_o),
        .wr_col_o           (wr_col_o),
        .wr_target_o        (wr_target_o),
        .dataflow_o         (dataflow_o),
        .done_o             (done_o),
        .err_o              (err_o)
    );

    // Builds a control word; mode, read_target and the spare top bits are random noise.
    function automatic logic [15:0] make_ctrl(input bit start, input int n, input int k, input int m,
                                              input logic [1:0] wt, input logic [1:0] df);
        logic [31:0] r;
        logic [15:0] c;
        r = $urandom;
        c = r[15:0];
        c[0]     = start;
        c[3:2]   = wt;
        c[7:6]   = df;
        c[9:8]   = 2'(n - 1);
        c[11:10] = 2'(k - 1);
        c[13:12] = 2'(m - 1);
        return c;
    endfunction

    function automatic logic [15:0] out_vec();
        return {busy_o, pe_clr_o, feed_en_o, feed_idx_o, wr_en_o, wr_row_o, wr_col_o,
                done_o, wr_target_o, dataflow_o, err_o};
    endfunction

    // Launches one job and compares every output each cycle against the phase schedule.
    // perturb: drop start, then re-raise it mid-FEED with different fields.
    // wr_pulse: if nonzero, pulse ctrl_wr_i during cycle wr_pulse.
    task automatic run_job(input int n, input int k, input int m, input bit perturb, input int wr_pulse);
        logic [1:0]  wt, df;
        logic [15:0] exp_v, got_v;
        int L, w, done_cnt;
        bit e_busy, e_clr, e_feed, e_wr, e_done;
        logic [1:0] e_idx, e_row, e_col;
        wt = 2'($urandom);
        df = 2'($urandom);
        L = k + n + m + n * m + 1;
        done_cnt = 0;
        ctrl_wr_i = 1'b0;
        control_register_i = make_ctrl(1'b0, n, k, m, wt, df);
        @(posedge clk_i); #1;
        control_register_i = make_ctrl(1'b1, n, k, m, wt, df);
        for (int c = 1; c <= L + 2; c++) begin
            @(posedge clk_i); #1;
            e_busy = (c <= L);
            e_clr  = (c == 1);
            e_feed = (c >= 2) && (c <= k + 1);
            e_idx  = e_feed ? 2'(c - 2) : 2'd0;
            e_wr   = (c >= k + n + m + 1) && (c <= L - 1);
            w      = c - (k + n + m + 1);
            e_row  = e_wr ? 2'(w / m) : 2'd0;
            e_col  = e_wr ? 2'(w % m) : 2'd0;
            e_done = (c == L);
`ifdef MATMUL_SEQ_ERR_CHECK_EN
            if (c == 1) err_model = 1'b0;
            if (wr_pulse != 0 && c == wr_pulse + 1) err_model = 1'b1;
`endif
            exp_v = {e_busy, e_clr, e_feed, e_idx, e_wr, e_row, e_col, e_done, wt, df, err_model};
            got_v = out_vec();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("[TB] FAIL job%0dx%0dx%0d cycle %0d: got %h expected %h", n, k, m, c, got_v, exp_v);
            end
            if (done_o === 1'b1) done_cnt++;
            if (perturb && c == 1)
                control_register_i[0] = 1'b0;
            if (perturb && c == 2)
                control_register_i = make_ctrl(1'b1, 5 - n, 5 - k, 5 - m, ~wt, ~df);
            ctrl_wr_i = (wr_pulse != 0 && c == wr_pulse);
        end
        ctrl_wr_i = 1'b0;
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("[TB] FAIL done_count job%0dx%0dx%0d: got %0d expected 1", n, k, m, done_cnt);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        ctrl_wr_i = 1'b0;
        control_register_i = make_ctrl(1'b1, 4, 4, 4, 2'd3, 2'd3);
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if (out_vec() !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected 0000", out_vec());
        end
        rst_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_i); #1;
            checks++;
            if (busy_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_held_start cycle %0d: busy got %b expected 0", i, busy_o);
            end
        end
    endtask

    task automatic test_basic();
        run_job(2, 3, 2, 1'b0, 0);
    endtask

    task automatic test_min();
        run_job(1, 1, 1, 1'b0, 0);
    endtask

    task automatic test_max();
        run_job(4, 4, 4, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++)
            run_job(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), 1'b0, 0);
    endtask

    task automatic test_restart_ignored();
        run_job(3, 3, 2, 1'b1, 0);
    endtask

    task automatic test_reset_mid_job();
        int bad;
        ctrl_wr_i = 1'b0;
        control_register_i = make_ctrl(1'b0, 3, 3, 3, 2'd2, 2'd1);
        @(posedge clk_i); #1;
        control_register_i = make_ctrl(1'b1, 3, 3, 3, 2'd2, 2'd1);
        // Cycle 11 is the second WRITE cycle for a 3x3x3 job.
        repeat (11) @(posedge clk_i);
        #1;
        checks++;
        if (wr_en_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midjob_in_write: wr_en got %b expected 1", wr_en_o);
        end
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        err_model = 1'b0;
        checks++;
        if (out_vec() !== 16'h0) begin
            errors++;
            $display("[TB] FAIL midjob_reset_outputs: got %h expected 0000", out_vec());
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i); #1;
            if (busy_o !== 1'b0 || done_o !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL midjob_no_relaunch: got %0d active cycles expected 0", bad);
        end
    endtask

    task automatic test_err();
        // Pulse lands in the first DRAIN cycle (K+2) of a 2x2x3 job.
        run_job(2, 2, 3, 1'b0, 4);
        ctrl_wr_i = 1'b1;
        @(posedge clk_i); #1;
        ctrl_wr_i = 1'b0;
        @(posedge clk_i); #1;
        checks++;
        if (err_o !== err_model) begin
            errors++;
            $display("[TB] FAIL err_idle_write: got %b expected %b", err_o, err_model);
        end
        run_job(1, 1, 1, 1'b0, 0);
    endtask

    initial begin
        rst_i = 1'b1;
        ctrl_wr_i = 1'b0;
        control_register_i = 16'h0;
        test_reset();
        test_basic();
        test_min();
        test_max();
        test_random();
        test_restart_ignored();
        test_reset_mid_job();
        test_err();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
